// File: rtl/icache_assoc_datapath.sv
// Set-associative instruction-cache datapath: tag/valid/data arrays, hit detection,
// victim selection with per-set round-robin, refill sequencing. Macro ICACHE_CRITICAL_WORD_FIRST_EN selects refill order.
module icache_assoc_datapath #(
  parameter  int LINE_SIZE  = 32,
  parameter  int CACHE_SIZE = 1024,
  parameter  int XLEN       = 32,
  parameter  int NUM_WAYS   = 2,
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pipe_req_address,
  output logic [XLEN-1:0]   pipe_fetched_word,
  output logic [XLEN-1:0]   l2_req_address,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              load_mode,
  input  logic              perform_write,
  input  logic              set_new_l2_block_address,
  input  logic              start_refill,
  input  logic              advance_refill,
  input  logic              finish_new_line_install,
  input  logic              invalidate_all,
  output logic              refill_done,
  output logic              valid_block_match,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way
);
  localparam int NUM_SETS = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int WPL      = LINE_SIZE / (XLEN / 8);
  localparam int OFF_BITS = $clog2(LINE_SIZE);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int SET_W    = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int WORD_W   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int TAG_W    = XLEN - OFF_BITS - SET_BITS;
  localparam int BLK_W    = XLEN - OFF_BITS;

  if ((LINE_SIZE % 4 != 0) || (CACHE_SIZE % 4 != 0) || (NUM_SETS < 1) || (NUM_WAYS < 1) ||
      ((NUM_WAYS & (NUM_WAYS - 1)) != 0) || (XLEN != 32)) begin : g_bad_cfg
    $error("icache_assoc_datapath: illegal parameter combination");
  end

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q;
  logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]                   data_q [NUM_SETS][NUM_WAYS][WPL];

  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              vic_rr_q, vic_rr_d;
  logic [WORD_W-1:0] beats_q, beats_d;
  logic [WORD_W-1:0] ridx_q, ridx_d;

  logic [SET_W-1:0]    req_set, blk_set;
  logic [TAG_W-1:0]    req_tag, blk_tag;
  logic [WORD_W-1:0]   req_word, ridx_start, ridx_step;
  logic [NUM_WAYS-1:0] match;
  logic                free_found;
  logic [WAY_W-1:0]    free_way, rr_inc, rd_way;
  logic [WORD_W-1:0]   rd_word;

  // Address fields are extracted by shift/mask so degenerate widths (one set, one word) still elaborate.
  assign req_set  = SET_W'((pipe_req_address >> OFF_BITS) & XLEN'(NUM_SETS - 1));
  assign req_tag  = TAG_W'(pipe_req_address >> (OFF_BITS + SET_BITS));
  assign req_word = WORD_W'((pipe_req_address >> 2) & XLEN'(WPL - 1));
  assign blk_set  = SET_W'(blk_q & BLK_W'(NUM_SETS - 1));
  assign blk_tag  = TAG_W'(blk_q >> SET_BITS);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign match[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
  end
  assign valid_block_match = |match;

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[req_set][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
  end

  assign rr_inc = WAY_W'((int'(rr_q[blk_set]) + 1) % NUM_WAYS);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign ridx_start = req_word;
  assign ridx_step  = (ridx_q == WORD_W'(WPL - 1)) ? '0 : ridx_q + WORD_W'(1);
`else
  assign ridx_start = WORD_W'(WPL - 1);
  assign ridx_step  = (ridx_q == '0) ? WORD_W'(WPL - 1) : ridx_q - WORD_W'(1);
`endif

  always_comb begin
    blk_d    = blk_q;
    victim_d = victim_q;
    vic_rr_d = vic_rr_q;
    beats_d  = beats_q;
    ridx_d   = ridx_q;
    if (set_new_l2_block_address) begin
      blk_d    = BLK_W'(pipe_req_address >> OFF_BITS);
      victim_d = free_found ? free_way : rr_q[req_set];
      vic_rr_d = !free_found;
    end
    if (start_refill) begin
      beats_d = WORD_W'(WPL - 1);
      ridx_d  = ridx_start;
    end else if (advance_refill) begin
      beats_d = (beats_q == '0) ? '0 : beats_q - WORD_W'(1);
      ridx_d  = ridx_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rr_q     <= '0;
      blk_q    <= '0;
      victim_q <= '0;
      vic_rr_q <= 1'b0;
      beats_q  <= '0;
      ridx_q   <= '0;
    end else begin
      blk_q    <= blk_d;
      victim_q <= victim_d;
      vic_rr_q <= vic_rr_d;
      beats_q  <= beats_d;
      ridx_q   <= ridx_d;
      if (invalidate_all) begin
        valid_q <= '0;
      end else if (finish_new_line_install) begin
        valid_q[blk_set][victim_q] <= 1'b1;
        if (vic_rr_q) rr_q[blk_set] <= rr_inc;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (finish_new_line_install && !invalidate_all) tag_q[blk_set][victim_q] <= blk_tag;
    if (perform_write) data_q[blk_set][victim_q][ridx_q] <= l2_fetched_word;
  end

  assign rd_way            = load_mode ? victim_q : hit_way;
  assign rd_word           = load_mode ? ridx_q : req_word;
  assign pipe_fetched_word = data_q[req_set][rd_way][rd_word];
  assign l2_req_address    = (XLEN'(blk_q) << OFF_BITS) | (XLEN'(ridx_q) << 2);
  assign refill_done       = (beats_q == '0);
  assign victim_way        = victim_q;

endmodule
